// File: rtl/coincidence_align_sequencer_if.sv
// CSR write/readback bus between the alignment sequencer (master) and a
// coincidenceRecorder (slave).
interface coincidence_align_sequencer_if;
  logic        csrStrobe;
  logic [31:0] csrData;
  logic [31:0] csrReadback;

  modport master (output csrStrobe, output csrData, input csrReadback);
  modport slave  (input csrStrobe, input csrData, output csrReadback);
endinterface

// File: rtl/coincidence_align_sequencer.sv
// Runs acquire / scan / offset-write / realign on one coincidenceRecorder
// through its CSR strobe and readback, without software involvement.
module coincidence_align_sequencer #(
  parameter int BIN_COUNT       = 400,
  parameter int DATA_WIDTH      = 3,
  parameter int ADVANCE         = 5,
  parameter int SETTLE_CYCLES   = 16,
  parameter int ACQ_START_DELAY = 5,
  parameter int POLL_TIMEOUT    = 1000000
) (
  input  logic        sysClk,
  input  logic        sysReset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [23:0] risingEdge,
  output logic [15:0] edgeCount,
  coincidence_align_sequencer_if.master csr
);

  localparam logic [31:0] DLY_LAST  = 32'(ACQ_START_DELAY - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_TIMEOUT - 1);
  localparam logic [31:0] SAMPLE_AT = 32'(SETTLE_CYCLES);
  localparam logic [23:0] LAST_BIN  = 24'(BIN_COUNT - 1);
  localparam logic [24:0] BIN25     = 25'(BIN_COUNT);
  localparam logic [24:0] ADV25     = 25'(ADVANCE);

  typedef enum logic [3:0] {
    S_IDLE, S_ACQ_WR, S_ACQ_DLY, S_ACQ_POLL, S_SCAN_WR,
    S_SCAN_SETTLE, S_SCAN_END, S_ALIGN_WR, S_REALIGN_WR, S_FINISH
  } state_t;

  state_t      state_q;
  logic        busy_q, done_q, strobe_q, prev_v_q;
  logic [31:0] data_q, cnt_q;
  logic [1:0]  status_q;
  logic [23:0] a_q, edge_q;
  logic [15:0] edge_cnt_q;

  logic        v_d, rise_d;
  logic [15:0] edge_cnt_d;
  logic [24:0] sum_d, offset_d;
  logic        unused_rb;

  assign unused_rb = ^csr.csrReadback[30:DATA_WIDTH];

  always_comb begin
    v_d        = (csr.csrReadback[DATA_WIDTH-1:0] != '0);
    rise_d     = v_d && !prev_v_q && (a_q != 24'd0);
    edge_cnt_d = (edge_cnt_q == 16'hFFFF) ? edge_cnt_q : edge_cnt_q + 16'd1;
    // edge < BIN_COUNT, so one conditional subtraction completes the modulo
    sum_d      = {1'b0, edge_q} + BIN25 - ADV25;
    offset_d   = (sum_d >= BIN25) ? sum_d - BIN25 : sum_d;
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
      data_q     <= '0;
      status_q   <= 2'd0;
      edge_q     <= '0;
      edge_cnt_q <= '0;
      a_q        <= '0;
      prev_v_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      strobe_q <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          // done_q high means this is the done cycle, where start is ignored
          if (start && !done_q) begin
            state_q    <= S_ACQ_WR;
            busy_q     <= 1'b1;
            status_q   <= 2'd0;
            edge_q     <= '0;
            edge_cnt_q <= '0;
          end
        end
        S_ACQ_WR: begin
          strobe_q <= 1'b1;
          data_q   <= 32'h8000_0000;
          cnt_q    <= '0;
          state_q  <= S_ACQ_DLY;
        end
        S_ACQ_DLY: begin
          if (cnt_q == DLY_LAST) begin
            cnt_q   <= '0;
            state_q <= S_ACQ_POLL;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_ACQ_POLL: begin
          if (!csr.csrReadback[31]) begin
            a_q        <= '0;
            prev_v_q   <= 1'b0;
            edge_q     <= '0;
            edge_cnt_q <= '0;
            state_q    <= S_SCAN_WR;
          end else if (cnt_q == POLL_LAST) begin
            status_q <= 2'd2;
            state_q  <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_SCAN_WR: begin
          strobe_q <= 1'b1;
          data_q   <= {8'h00, a_q};
          cnt_q    <= '0;
          state_q  <= S_SCAN_SETTLE;
        end
        S_SCAN_SETTLE: begin
          if (cnt_q == SAMPLE_AT) begin
            prev_v_q <= v_d;
            if (rise_d) begin
              edge_q     <= a_q;
              edge_cnt_q <= edge_cnt_d;
            end
            if (a_q == LAST_BIN) begin
              state_q <= S_SCAN_END;
            end else begin
              a_q     <= a_q + 24'd1;
              state_q <= S_SCAN_WR;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_SCAN_END: begin
          if (edge_cnt_q == 16'd0) begin
            status_q <= 2'd1;
            state_q  <= S_FINISH;
          end else begin
            state_q <= S_ALIGN_WR;
          end
        end
        S_ALIGN_WR: begin
          strobe_q <= 1'b1;
          data_q   <= {3'b010, 5'h00, offset_d[23:0]};
          state_q  <= S_REALIGN_WR;
        end
        S_REALIGN_WR: begin
          // hold one cycle so the realign strobe never abuts the align strobe
          if (!strobe_q) begin
            strobe_q <= 1'b1;
            data_q   <= 32'h2000_0000;
            status_q <= 2'd0;
            state_q  <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign status        = status_q;
  assign risingEdge    = edge_q;
  assign edgeCount     = edge_cnt_q;
  assign csr.csrStrobe = strobe_q;
  assign csr.csrData   = data_q;

endmodule

// File: tb/tb_coincidence_align_sequencer.sv
// Scoreboard bench: a recorder model answers CSR traffic, a reference model
// predicts every write and the end-of-sequence results.
module tb_coincidence_align_sequencer;

  localparam int BIN  = 400;
  localparam int ADV  = 5;
  localparam int PTO  = 100;

  logic        sysClk = 1'b0;
  logic        sysReset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [1:0]  status;
  logic [23:0] risingEdge;
  logic [15:0] edgeCount;

  coincidence_align_sequencer_if bus ();

  coincidence_align_sequencer #(
    .BIN_COUNT(BIN), .DATA_WIDTH(3), .ADVANCE(ADV), .SETTLE_CYCLES(16),
    .ACQ_START_DELAY(5), .POLL_TIMEOUT(PTO)
  ) dut (
    .sysClk(sysClk), .sysReset(sysReset), .start(start), .busy(busy),
    .done(done), .status(status), .risingEdge(risingEdge),
    .edgeCount(edgeCount), .csr(bus)
  );

  always #5 sysClk = ~sysClk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  // Recorder model: histogram channel 0 contents and acquisition busy flag
  bit          high[BIN];
  logic [2:0]  cval[BIN];
  int          acq_lat = 30;
  int          busy_left = 0;
  bit          stuck = 0;
  logic [23:0] addr = '0;

  always @(negedge sysClk) begin
    logic [2:0] c;
    if (sysReset) busy_left = 0;
    if (bus.csrStrobe) begin
      if (bus.csrData[31]) busy_left = acq_lat;
      else if (bus.csrData[31:24] == 8'h00) addr = bus.csrData[23:0];
    end else if (busy_left > 0) begin
      busy_left--;
    end
    c = (int'(addr) < BIN && high[addr]) ? cval[addr] : 3'd0;
    bus.csrReadback = {(stuck || busy_left > 0), 28'($urandom), c};
  end

  // Scoreboard queues
  logic [31:0] exp_wr[$];
  logic [41:0] exp_res[$];   // {status, risingEdge, edgeCount}

  task automatic compute_expect(input bit stuck_i);
    int cnt, last, off;
    exp_wr.push_back(32'h8000_0000);
    if (stuck_i) begin
      exp_res.push_back({2'd2, 24'd0, 16'd0});
      return;
    end
    for (int a = 0; a < BIN; a++) exp_wr.push_back(32'(a));
    cnt = 0;
    last = 0;
    for (int a = 1; a < BIN; a++)
      if (high[a] && !high[a-1]) begin
        cnt++;
        last = a;
      end
    if (cnt > 0) begin
      off = ((last - ADV) % BIN + BIN) % BIN;
      exp_wr.push_back(32'h4000_0000 | 32'(off));
      exp_wr.push_back(32'h2000_0000);
      exp_res.push_back({2'd0, 24'(last), 16'(cnt)});
    end else begin
      exp_res.push_back({2'd1, 24'd0, 16'd0});
    end
  endtask

  // Monitor
  logic prev_strobe = 1'b0;
  always @(negedge sysClk) begin
    logic [31:0] w;
    logic [41:0] r;
    if (!sysReset) begin
      if (bus.csrStrobe) begin
        check("strobe_spacing", 64'(prev_strobe), 64'd0);
        if (exp_wr.size() == 0) begin
          check("unexpected_write", 64'(bus.csrData), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          check("csr_write", 64'(bus.csrData), 64'(w));
        end
      end else begin
        check("data_idle_zero", 64'(bus.csrData), 64'd0);
      end
      if (done) begin
        check("busy_at_done", 64'(busy), 64'd0);
        check("writes_pending_at_done", 64'(exp_wr.size()), 64'd0);
        if (exp_res.size() == 0) begin
          check("unexpected_done", 64'(exp_res.size()), 64'd1);
        end else begin
          r = exp_res.pop_front();
          check("status", 64'(status), 64'(r[41:40]));
          check("risingEdge", 64'(risingEdge), 64'(r[39:16]));
          check("edgeCount", 64'(edgeCount), 64'(r[15:0]));
        end
      end
    end
    prev_strobe = sysReset ? 1'b0 : bus.csrStrobe;
  end

  task automatic pulse_start();
    @(negedge sysClk) start = 1'b1;
    @(negedge sysClk) start = 1'b0;
  endtask

  // Returns on the negedge where done is visible
  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge sysClk);
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic clear_hist();
    for (int a = 0; a < BIN; a++) begin
      high[a] = 1'b0;
      cval[a] = 3'($urandom_range(1, 7));
    end
  endtask

  task automatic set_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) high[a] = 1'b1;
  endtask

  task automatic random_hist();
    bit p;
    clear_hist();
    p = 1'($urandom_range(0, 1));
    for (int a = 0; a < BIN; a++) begin
      if ($urandom_range(0, 39) == 0) p = !p;
      high[a] = p;
    end
  endtask

  task automatic run_full(input int lat);
    acq_lat = lat;
    compute_expect(1'b0);
    pulse_start();
    wait_done(10000);
    @(negedge sysClk);
  endtask

  initial begin
    clear_hist();
    repeat (3) @(negedge sysClk);
    sysReset = 1'b0;
    @(negedge sysClk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_strobe", 64'(bus.csrStrobe), 64'd0);
    check("rst_status", 64'(status), 64'd0);
    check("rst_risingEdge", 64'(risingEdge), 64'd0);
    check("rst_edgeCount", 64'(edgeCount), 64'd0);

    // Bins 120..180; extra starts while busy and on the done cycle
    set_range(120, 180);
    acq_lat = 30;
    compute_expect(1'b0);
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    repeat (600) @(negedge sysClk);
    pulse_start();
    repeat (3) @(negedge sysClk);
    pulse_start();
    wait_done(10000);
    start = 1'b1;
    @(negedge sysClk) start = 1'b0;
    repeat (60) @(negedge sysClk);
    check("start_on_done_ignored", 64'(busy), 64'd0);

    // Bin 0 high must not count; edge 300
    clear_hist();
    set_range(0, 2);
    set_range(300, 399);
    run_full(30);

    // Edge at bin 3: offset wraps to 398
    clear_hist();
    set_range(3, 10);
    run_full(30);

    // No edges
    clear_hist();
    run_full(30);

    // Acquisition never completes
    stuck = 1'b1;
    compute_expect(1'b1);
    pulse_start();
    wait_done(500);
    @(negedge sysClk);
    stuck = 1'b0;

    // Random histograms and acquisition latencies
    for (int k = 0; k < 2; k++) begin
      random_hist();
      run_full(int'($urandom_range(2, 60)));
    end

    // Reset mid-scan, then a clean restart
    random_hist();
    acq_lat = 20;
    compute_expect(1'b0);
    pulse_start();
    repeat (2000) @(negedge sysClk);
    sysReset = 1'b1;
    exp_wr.delete();
    exp_res.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge sysClk);
      check("reset_strobe_low", 64'(bus.csrStrobe), 64'd0);
      check("reset_busy_low", 64'(busy), 64'd0);
    end
    sysReset = 1'b0;
    repeat (30) @(negedge sysClk);
    check("post_reset_idle", 64'(busy), 64'd0);
    run_full(20);

    repeat (5) @(negedge sysClk);
    check("results_all_consumed", 64'(exp_res.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
